pipeline_hazard_controller: RTL and testbench

- Central sequencing unit for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates write-enable, flush and bubble controls for:
  - load-use hazards;
  - taken branches resolved in MEM (beq flag carried in EX/MEM);
  - fixed-latency data-memory accesses that freeze the pipeline.
- Keeps saturating performance counters for stall and flush events.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/pipeline_hazard_controller_if.sv | 46 ++++
 rtl/pipeline_hazard_controller_counter.sv | 22 ++
 rtl/pipeline_hazard_controller.sv | 115 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding,
// register-index width and the hard-wired zero register.
package pipeline_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // True when the instruction in ID/EX is a load whose destination feeds the
  // instruction currently in IF/ID.
  function automatic logic load_use_hit(
    input logic                 mem_read,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] rs1,
    input logic [REG_IDX_W-1:0] rs2,
    input logic                 uses_rs2
  );
    return mem_read && (rd != REG_ZERO) &&
           ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle of pipeline-register status inputs and sequencing outputs.
// slave = the hazard controller, master = the pipeline datapath side.
interface pipeline_hazard_controller_if #(
  parameter int COUNTER_WIDTH = 32
);
  logic [pipeline_pkg::REG_IDX_W-1:0] id_rs1;
  logic [pipeline_pkg::REG_IDX_W-1:0] id_rs2;
  logic                               id_uses_rs2;
  logic                               id_ex_mem_read;
  logic [pipeline_pkg::REG_IDX_W-1:0] id_ex_rd;
  logic                               ex_mem_mem_read;
  logic                               ex_mem_mem_write;
  logic                               ex_mem_beq_instruction;
  logic                               ex_mem_flag_beq;

  logic                               pc_write;
  logic                               pc_src;
  logic                               if_id_write;
  logic                               if_id_flush;
  logic                               id_ex_write;
  logic                               id_ex_flush;
  logic                               ex_mem_write;
  logic                               ex_mem_flush;
  logic                               mem_wb_bubble;
  logic [COUNTER_WIDTH-1:0]           stall_count;
  logic [COUNTER_WIDTH-1:0]           flush_count;
  logic                               busy;

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, id_ex_mem_read, id_ex_rd,
           ex_mem_mem_read, ex_mem_mem_write, ex_mem_beq_instruction,
           ex_mem_flag_beq,
    output pc_write, pc_src, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_bubble,
           stall_count, flush_count, busy
  );

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, id_ex_mem_read, id_ex_rd,
           ex_mem_mem_read, ex_mem_mem_write, ex_mem_beq_instruction,
           ex_mem_flag_beq,
    input  pc_write, pc_src, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_bubble,
           stall_count, flush_count, busy
  );
endinterface

// File: rtl/pipeline_hazard_controller_counter.sv
// Saturating event counter used for the stall and flush statistics.
module hazard_event_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] r_count;

  // Count qualifying events, holding at all-ones instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Sequencing unit for the IF/ID, ID/EX, EX/MEM and MEM/WB registers:
// memory freeze, taken-branch flush and load-use stall, in that priority.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int DMEM_WAIT_CYCLES = 2,
  parameter int COUNTER_WIDTH    = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  pipeline_hazard_controller_if.slave  hz
);
  // Wait counter only needs to hold DMEM_WAIT_CYCLES-1.
  localparam int            WCW       = (DMEM_WAIT_CYCLES > 1) ? $clog2(DMEM_WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'((DMEM_WAIT_CYCLES > 0) ? DMEM_WAIT_CYCLES - 1 : 0);
  localparam logic          HAS_WAIT  = (DMEM_WAIT_CYCLES > 0);

  logic [0:0]     r_state;
  logic [WCW-1:0] r_wait_cnt;

  logic w_mem_op;
  logic w_freeze;
  logic w_branch;
  logic w_load_use;
  logic w_stall_inc;
  logic w_flush_inc;

  logic w_pc_write, w_pc_src, w_if_id_write, w_if_id_flush;
  logic w_id_ex_write, w_id_ex_flush, w_ex_mem_write, w_ex_mem_flush;
  logic w_mem_wb_bubble;

  assign w_mem_op = hz.ex_mem_mem_read | hz.ex_mem_mem_write;

  // The release cycle (MEM_WAIT with wait_cnt==0) is never frozen, which
  // also keeps the still-present memory op from re-triggering a freeze.
  assign w_freeze = (r_state == ST_RUN) ? (w_mem_op && HAS_WAIT)
                                        : (r_wait_cnt != '0);

  assign w_branch   = !w_freeze && hz.ex_mem_beq_instruction && hz.ex_mem_flag_beq;
  assign w_load_use = !w_freeze && !w_branch &&
                      load_use_hit(hz.id_ex_mem_read, hz.id_ex_rd, hz.id_rs1,
                                   hz.id_rs2, hz.id_uses_rs2);

  assign w_stall_inc = w_freeze || w_load_use;
  assign w_flush_inc = w_branch;

  // Decode pipeline-register controls; everything is forced low during reset.
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_src        = 1'b0;
    w_if_id_write   = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_write   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_write  = 1'b0;
    w_ex_mem_flush  = 1'b0;
    w_mem_wb_bubble = 1'b0;
    if (reset) begin
      // hold everything off
    end else if (w_freeze) begin
      w_mem_wb_bubble = 1'b1;
    end else begin
      w_pc_write     = !w_load_use;
      w_if_id_write  = !w_load_use;
      w_id_ex_write  = 1'b1;
      w_ex_mem_write = 1'b1;
      w_id_ex_flush  = w_load_use || w_branch;
      w_pc_src       = w_branch;
      w_if_id_flush  = w_branch;
      w_ex_mem_flush = w_branch;
    end
  end

  // Freeze FSM: DMEM_WAIT_CYCLES frozen cycles, then one release cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_freeze) begin
        r_state    <= ST_MEM_WAIT;
        r_wait_cnt <= WAIT_LOAD;
      end
    end else if (r_wait_cnt != '0) begin
      r_wait_cnt <= r_wait_cnt - WCW'(1);
    end else begin
      r_state <= ST_RUN;
    end
  end

  assign hz.pc_write      = w_pc_write;
  assign hz.pc_src        = w_pc_src;
  assign hz.if_id_write   = w_if_id_write;
  assign hz.if_id_flush   = w_if_id_flush;
  assign hz.id_ex_write   = w_id_ex_write;
  assign hz.id_ex_flush   = w_id_ex_flush;
  assign hz.ex_mem_write  = w_ex_mem_write;
  assign hz.ex_mem_flush  = w_ex_mem_flush;
  assign hz.mem_wb_bubble = w_mem_wb_bubble;
  assign hz.busy          = (r_state == ST_MEM_WAIT);

  hazard_event_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_stall_inc),
    .count (hz.stall_count)
  );

  hazard_event_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_flush_inc),
    .count (hz.flush_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: a DMEM_WAIT_CYCLES=2 / 32-bit build
// checked through an expectation queue, plus a DMEM_WAIT_CYCLES=0 / 4-bit
// build for the no-freeze and saturation cases.
module tb_pipeline_hazard_controller;
  // control vector order:
  // {pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
  //  ex_mem_write, ex_mem_flush, mem_wb_bubble}
  localparam logic [8:0] C_OFF = 9'b000000000;
  localparam logic [8:0] C_DEF = 9'b101010100;
  localparam logic [8:0] C_LU  = 9'b000011100;
  localparam logic [8:0] C_BR  = 9'b111111110;
  localparam logic [8:0] C_FRZ = 9'b000000001;

  typedef struct {
    string       tag;
    logic [8:0]  ctrl;
    logic        busy;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  pipeline_hazard_controller_if #(.COUNTER_WIDTH(32)) if_main ();
  pipeline_hazard_controller_if #(.COUNTER_WIDTH(4))  if_d0 ();

  pipeline_hazard_controller #(.DMEM_WAIT_CYCLES(2), .COUNTER_WIDTH(32)) dut_main (
    .clock (clock),
    .reset (reset),
    .hz    (if_main)
  );

  pipeline_hazard_controller #(.DMEM_WAIT_CYCLES(0), .COUNTER_WIDTH(4)) dut_d0 (
    .clock (clock),
    .reset (reset),
    .hz    (if_d0)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] main_ctrl();
    return {if_main.pc_write, if_main.pc_src, if_main.if_id_write, if_main.if_id_flush,
            if_main.id_ex_write, if_main.id_ex_flush, if_main.ex_mem_write,
            if_main.ex_mem_flush, if_main.mem_wb_bubble};
  endfunction

  function automatic logic [8:0] d0_ctrl();
    return {if_d0.pc_write, if_d0.pc_src, if_d0.if_id_write, if_d0.if_id_flush,
            if_d0.id_ex_write, if_d0.id_ex_flush, if_d0.ex_mem_write,
            if_d0.ex_mem_flush, if_d0.mem_wb_bubble};
  endfunction

  task automatic drive_main(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses_rs2,
                            input logic mr, input logic [4:0] rd, input logic emr,
                            input logic emw, input logic beq, input logic flag);
    if_main.id_rs1                 = rs1;
    if_main.id_rs2                 = rs2;
    if_main.id_uses_rs2            = uses_rs2;
    if_main.id_ex_mem_read         = mr;
    if_main.id_ex_rd               = rd;
    if_main.ex_mem_mem_read        = emr;
    if_main.ex_mem_mem_write       = emw;
    if_main.ex_mem_beq_instruction = beq;
    if_main.ex_mem_flag_beq        = flag;
  endtask

  task automatic push_exp(input string tag, input logic [8:0] ctrl, input logic busy,
                          input logic [31:0] stall, input logic [31:0] flush);
    exp_t e;
    e.tag = tag; e.ctrl = ctrl; e.busy = busy; e.stall = stall; e.flush = flush;
    sb_q.push_back(e);
  endtask

  task automatic sample_main();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      $display("[TB] %s ctrl=%b busy=%0b stall=%0d flush=%0d", e.tag, main_ctrl(),
               if_main.busy, if_main.stall_count, if_main.flush_count);
      check_eq({e.tag, ".ctrl"},  32'(main_ctrl()),        32'(e.ctrl));
      check_eq({e.tag, ".busy"},  32'(if_main.busy),       32'(e.busy));
      check_eq({e.tag, ".stall"}, if_main.stall_count,     e.stall);
      check_eq({e.tag, ".flush"}, if_main.flush_count,     e.flush);
    end
  endtask

  // Inputs already applied at a falling edge; check mid-cycle, then move on.
  task automatic step(input string tag, input logic [8:0] ctrl, input logic busy,
                      input logic [31:0] stall, input logic [31:0] flush);
    push_exp(tag, ctrl, busy, stall, flush);
    #2;
    sample_main();
    @(negedge clock);
  endtask

  initial begin
    drive_main(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    if_d0.id_rs1 = '0; if_d0.id_rs2 = '0; if_d0.id_uses_rs2 = 1'b0;
    if_d0.id_ex_mem_read = 1'b0; if_d0.id_ex_rd = '0;
    if_d0.ex_mem_mem_read = 1'b0; if_d0.ex_mem_mem_write = 1'b0;
    if_d0.ex_mem_beq_instruction = 1'b0; if_d0.ex_mem_flag_beq = 1'b0;

    // Reset holds every control low
    step("reset", C_OFF, 1'b0, 0, 0);
    reset = 1'b0;
    step("idle", C_DEF, 1'b0, 0, 0);

    // Load-use on rs1, then rd==x0 does not stall
    drive_main(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rs1", C_LU, 1'b0, 0, 0);
    drive_main(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rd0", C_DEF, 1'b0, 1, 0);

    // Load-use on rs2 only counts when rs2 is read
    drive_main(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rs2", C_LU, 1'b0, 1, 0);
    drive_main(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rs2_unused", C_DEF, 1'b0, 2, 0);

    // Taken branch beats a simultaneous load-use; not-taken leaves the stall
    drive_main(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    step("br_taken", C_BR, 1'b0, 2, 0);
    drive_main(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    step("br_not_taken", C_LU, 1'b0, 2, 1);
    drive_main(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("after_br", C_DEF, 1'b0, 3, 1);

    // Memory freeze: 2 frozen cycles, release cycle, back to RUN
    drive_main(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("frz_c1", C_FRZ, 1'b0, 3, 1);
    drive_main(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("frz_c2_br_masked", C_FRZ, 1'b1, 4, 1);
    drive_main(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("frz_release", C_DEF, 1'b1, 5, 1);
    drive_main(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("frz_run", C_DEF, 1'b0, 5, 1);

    // Reset asserted asynchronously in the first wait cycle
    drive_main(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rst_frz_c1", C_FRZ, 1'b0, 5, 1);
    push_exp("rst_frz_wait1", C_FRZ, 1'b1, 6, 1);
    #1;
    sample_main();
    #1;
    reset = 1'b1;
    push_exp("rst_async", C_OFF, 1'b0, 0, 0);
    #1;
    sample_main();
    @(negedge clock);
    drive_main(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step("rst_release", C_DEF, 1'b0, 0, 0);

    // DMEM_WAIT_CYCLES=0 build: memory ops never freeze
    if_d0.ex_mem_mem_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      $display("[TB] d0_memop cyc=%0d ctrl=%b busy=%0b", k, d0_ctrl(), if_d0.busy);
      check_eq($sformatf("d0_memop%0d.ctrl", k), 32'(d0_ctrl()), 32'(C_DEF));
      check_eq($sformatf("d0_memop%0d.busy", k), 32'(if_d0.busy), 32'd0);
      @(negedge clock);
    end
    if_d0.ex_mem_mem_read = 1'b0;

    // 4-bit stall counter saturates at 15 across back-to-back load-use cycles
    if_d0.id_ex_mem_read = 1'b1;
    if_d0.id_ex_rd       = 5'd3;
    if_d0.id_rs1         = 5'd3;
    for (int k = 0; k <= 20; k++) begin
      #2;
      $display("[TB] d0_sat cyc=%0d stall=%0d", k, if_d0.stall_count);
      check_eq($sformatf("d0_sat%0d.stall", k), 32'(if_d0.stall_count),
               (k > 15) ? 32'd15 : 32'(k));
      if (k == 0 || k == 20)
        check_eq($sformatf("d0_sat%0d.ctrl", k), 32'(d0_ctrl()), 32'(C_LU));
      @(negedge clock);
    end

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
